in_fm_tile_scheduler: RTL and testbench
=======================================

Name: in_fm_tile_scheduler

Overview:
Layer-level sequencer for the input-feature-map tile loader. It walks every input tile of an M x R x C feature map in the order col, then row, then m (col innermost). For each tile it drives the tile base coordinates, pulses the loader start, and waits for the loader's done. It then hands the tile to the convolution engine and issues the tile-clean pulse that rearms the loader's counters before moving to the next tile.

Parameters:
CW, 32, width of coordinate/counter buses
M, 32, input channels of the layer
R, 64, rows of the input feature map
C, 32, columns of the input feature map
Tm, 8, channel tile size
Tr, 16, row tile size
Tc, 8, column tile size

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
run  in  1  one-cycle pulse; starts a full layer pass
load_start  out  1  one-cycle pulse to the loader's start
load_done  in  1  loader done; held high until conv_tile_clean
conv_tile_clean  out  1  one-cycle pulse; clears loader counter, releases tile
tile_valid  out  1  level; current tile resident in FIFO, conv may consume
conv_tile_done  in  1  one-cycle pulse from conv engine; tile consumed
tile_base_m  out  CW  channel base of current tile
tile_base_row  out  CW  row base of current tile
tile_base_col  out  CW  column base of current tile
tile_idx  out  CW  ordinal of current tile, 0-based
busy  out  1  high from accepted run until layer_done
layer_done  out  1  one-cycle pulse after last tile cleaned

Behaviour:
- Reset values: all outputs 0, state IDLE, bases 0, tile_idx 0.
- States: IDLE, ISSUE, WAIT_LOAD, TILE_RDY, CLEAN, FINISH. All outputs are registered or decoded from state only; no combinational input-to-output paths.
- IDLE: on run=1, go to ISSUE. Bases and tile_idx are 0 and busy=1 from the next cycle.
- ISSUE: load_start=1 for exactly this cycle, then go to WAIT_LOAD. load_done is ignored in ISSUE, because the loader's done may still be deasserting.
- WAIT_LOAD: when load_done=1, go to TILE_RDY. There is no timeout.
- TILE_RDY: tile_valid=1. When conv_tile_done=1, go to CLEAN.
- CLEAN: conv_tile_clean=1 for this cycle only. At the exit edge the bases advance:
  - tile_base_col += Tc.
  - If the new col >= C: col=0 and tile_base_row += Tr.
  - If the new row >= R: row=0 and tile_base_m += Tm.
  - tile_idx increments.
  - If the finished tile was the last one (col+Tc>=C, row+Tr>=R, m+Tm>=M), go to FINISH and leave the bases at 0. Otherwise go to ISSUE.
- FINISH: layer_done=1 for one cycle, busy falls, return to IDLE.
- Bases are stable from ISSUE through CLEAN inclusive and change only at the CLEAN exit edge.
- Non-divisible dimensions: the last base is the largest multiple of the tile size that is < the dimension. Tile count = ceil(M/Tm)*ceil(R/Tr)*ceil(C/Tc). Out-of-range elements are zero-filled by the loader, not by this block.
- Arithmetic: compare on the CW-bit sum before assignment. Parameters are constrained so that dim+tile < 2^CW, so there is no wrap.
- run while busy=1 is ignored; no queueing.
- conv_tile_done outside TILE_RDY is ignored. load_done outside WAIT_LOAD is ignored.
- load_done and conv_tile_done arriving in the same cycle in WAIT_LOAD: take only the WAIT_LOAD transition. conv_tile_done is not remembered.
- Reset asserted mid-layer: immediate return to IDLE with all outputs 0. Any in-flight pulse is truncated. The loader is reset by the same rst.
- Minimum per-tile overhead is 4 cycles beyond the loader and conv latency (ISSUE, load_done detect, conv done detect, CLEAN).

Test Plan:
- M=16,R=32,C=16,Tm=8,Tr=16,Tc=8; single run; loader and conv models respond after 5 cycles → exactly 8 load_start pulses. Bases in order (m,row,col): (0,0,0),(0,0,8),(0,16,0),(0,16,8),(8,0,0),(8,0,8),(8,16,0),(8,16,8). One layer_done pulse; tile_idx reaches 7.
- C=20,Tc=8, others as above → column bases 0,8,16 per row; 12 tiles total; layer_done after the 12th conv_tile_clean.
- Loader done held high until clean → load_start is not re-pulsed and WAIT_LOAD is not re-entered early. conv_tile_clean is exactly one cycle, and load_done is seen low in the following ISSUE cycle.
- run pulsed again at tile 3 of 8 → ignored; tile sequence and count unchanged; busy stays high throughout.
- rst driven low while in TILE_RDY of tile 5 → within that cycle all outputs 0 and state IDLE. A new run restarts from base (0,0,0), tile_idx 0.
- conv_tile_done pulsed during WAIT_LOAD → no transition. tile_valid rises only after load_done and stays high until conv_tile_done is seen in TILE_RDY.

Source files
------------

// File: rtl/in_fm_tile_scheduler.sv
// Layer-level sequencer for the input-feature-map tile loader: walks every
// M x R x C input tile (col innermost, then row, then m) and handshakes loader and conv engine.
module in_fm_tile_scheduler #(
    parameter int unsigned CW = 32,
    parameter int unsigned M  = 32,
    parameter int unsigned R  = 64,
    parameter int unsigned C  = 32,
    parameter int unsigned Tm = 8,
    parameter int unsigned Tr = 16,
    parameter int unsigned Tc = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    output logic          load_start,
    input  logic          load_done,
    output logic          conv_tile_clean,
    output logic          tile_valid,
    input  logic          conv_tile_done,
    output logic [CW-1:0] tile_base_m,
    output logic [CW-1:0] tile_base_row,
    output logic [CW-1:0] tile_base_col,
    output logic [CW-1:0] tile_idx,
    output logic          busy,
    output logic          layer_done
);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitLoad,
        StTileRdy,
        StClean,
        StFinish
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] m_q, m_d;
    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] idx_q, idx_d;

    logic [CW-1:0] col_sum, row_sum, m_sum;
    logic          col_wrap, row_wrap, m_wrap, last_tile;

    // Sums are compared before assignment; dim + tile never wraps CW bits.
    assign col_sum   = col_q + CW'(Tc);
    assign row_sum   = row_q + CW'(Tr);
    assign m_sum     = m_q + CW'(Tm);
    assign col_wrap  = col_sum >= CW'(C);
    assign row_wrap  = row_sum >= CW'(R);
    assign m_wrap    = m_sum >= CW'(M);
    assign last_tile = col_wrap && row_wrap && m_wrap;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            m_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            row_q   <= row_d;
            col_q   <= col_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        row_d   = row_q;
        col_d   = col_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (run) begin
                    state_d = StIssue;
                    m_d     = '0;
                    row_d   = '0;
                    col_d   = '0;
                    idx_d   = '0;
                end
            end
            // load_done may still be falling from the previous tile here.
            StIssue: state_d = StWaitLoad;
            StWaitLoad: begin
                if (load_done) state_d = StTileRdy;
            end
            StTileRdy: begin
                if (conv_tile_done) state_d = StClean;
            end
            StClean: begin
                idx_d = idx_q + CW'(1);
                if (last_tile) begin
                    state_d = StFinish;
                    m_d     = '0;
                    row_d   = '0;
                    col_d   = '0;
                end else begin
                    state_d = StIssue;
                    if (col_wrap) begin
                        col_d = '0;
                        if (row_wrap) begin
                            row_d = '0;
                            m_d   = m_sum;
                        end else begin
                            row_d = row_sum;
                        end
                    end else begin
                        col_d = col_sum;
                    end
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    assign load_start      = (state_q == StIssue);
    assign tile_valid      = (state_q == StTileRdy);
    assign conv_tile_clean = (state_q == StClean);
    assign layer_done      = (state_q == StFinish);
    assign busy            = (state_q != StIdle) && (state_q != StFinish);
    assign tile_base_m     = m_q;
    assign tile_base_row   = row_q;
    assign tile_base_col   = col_q;
    assign tile_idx        = idx_q;

endmodule

// File: tb/tb_in_fm_tile_scheduler.sv
// Directed bench for in_fm_tile_scheduler: an 8-tile layer (C=16) and a 12-tile
// layer (C=20), with behavioural loader/conv responders driven from the stimulus thread.
module tb_in_fm_tile_scheduler;

    logic        clk;
    logic        rst;
    logic        run_a, ld_a, ctd_a, ls_a, clean_a, tv_a, busy_a, ldone_a;
    logic [31:0] bm_a, br_a, bc_a, idx_a;
    logic        run_b, ld_b, ctd_b, ls_b, clean_b, tv_b, busy_b, ldone_b;
    logic [31:0] bm_b, br_b, bc_b, idx_b;

    int n_assert = 0;
    int n_fail   = 0;

    // responder and monitor state
    bit auto_a;
    int ld_cnt_a, cv_cnt_a, ld_cnt_b, cv_cnt_b;
    bit cv_hold_a, cv_hold_b, clean_prev_a;
    int ls_cnt_a, ls_ld_a, clean_cnt_a, clean_wide_a, done_cnt_a;
    int ls_cnt_b, clean_cnt_b, done_cnt_b, clean_at_done_b;
    logic [31:0] q_m_a[$], q_r_a[$], q_c_a[$], q_i_a[$];
    logic [31:0] q_m_b[$], q_r_b[$], q_c_b[$];

    in_fm_tile_scheduler #(.CW(32), .M(16), .R(32), .C(16), .Tm(8), .Tr(16), .Tc(8)) u_dut_a (
        .clk(clk), .rst(rst), .run(run_a), .load_start(ls_a), .load_done(ld_a),
        .conv_tile_clean(clean_a), .tile_valid(tv_a), .conv_tile_done(ctd_a),
        .tile_base_m(bm_a), .tile_base_row(br_a), .tile_base_col(bc_a), .tile_idx(idx_a),
        .busy(busy_a), .layer_done(ldone_a)
    );

    in_fm_tile_scheduler #(.CW(32), .M(16), .R(32), .C(20), .Tm(8), .Tr(16), .Tc(8)) u_dut_b (
        .clk(clk), .rst(rst), .run(run_b), .load_start(ls_b), .load_done(ld_b),
        .conv_tile_clean(clean_b), .tile_valid(tv_b), .conv_tile_done(ctd_b),
        .tile_base_m(bm_b), .tile_base_row(br_b), .tile_base_col(bc_b), .tile_idx(idx_b),
        .busy(busy_b), .layer_done(ldone_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_a();
        ld_cnt_a = 0; cv_cnt_a = 0; cv_hold_a = 0; ld_a = 0; ctd_a = 0;
        ls_cnt_a = 0; ls_ld_a = 0; clean_cnt_a = 0; clean_wide_a = 0; done_cnt_a = 0;
        q_m_a.delete(); q_r_a.delete(); q_c_a.delete(); q_i_a.delete();
    endtask

    // One clock: sample #1 after the edge, then update the responders (loader done
    // 5 cycles after load_start, held until clean; conv done 5 cycles into tile_valid).
    task automatic tick();
        @(posedge clk);
        #1;
        if (ls_a) begin
            ls_cnt_a++;
            if (ld_a) ls_ld_a++;
            q_m_a.push_back(bm_a); q_r_a.push_back(br_a);
            q_c_a.push_back(bc_a); q_i_a.push_back(idx_a);
        end
        if (clean_a) begin
            clean_cnt_a++;
            if (clean_prev_a) clean_wide_a++;
        end
        clean_prev_a = clean_a;
        if (ldone_a) done_cnt_a++;
        if (auto_a) begin
            if (clean_a) ld_a = 1'b0;
            if (ld_cnt_a > 0) begin
                ld_cnt_a--;
                if (ld_cnt_a == 0) ld_a = 1'b1;
            end else if (ls_a) ld_cnt_a = 5;
            ctd_a = 1'b0;
            if (cv_cnt_a > 0) begin
                cv_cnt_a--;
                if (cv_cnt_a == 0) begin ctd_a = 1'b1; cv_hold_a = 1'b1; end
            end else if (tv_a && !cv_hold_a) cv_cnt_a = 5;
            if (!tv_a) cv_hold_a = 1'b0;
        end
        if (ls_b) begin
            ls_cnt_b++;
            q_m_b.push_back(bm_b); q_r_b.push_back(br_b); q_c_b.push_back(bc_b);
        end
        if (clean_b) clean_cnt_b++;
        if (ldone_b) begin done_cnt_b++; clean_at_done_b = clean_cnt_b; end
        if (clean_b) ld_b = 1'b0;
        if (ld_cnt_b > 0) begin
            ld_cnt_b--;
            if (ld_cnt_b == 0) ld_b = 1'b1;
        end else if (ls_b) ld_cnt_b = 5;
        ctd_b = 1'b0;
        if (cv_cnt_b > 0) begin
            cv_cnt_b--;
            if (cv_cnt_b == 0) begin ctd_b = 1'b1; cv_hold_b = 1'b1; end
        end else if (tv_b && !cv_hold_b) cv_cnt_b = 5;
        if (!tv_b) cv_hold_b = 1'b0;
    endtask

    initial begin
        int k;
        int busy_low;
        bit rerun;
        logic [31:0] o;

        rst = 1'b0; run_a = 1'b0; run_b = 1'b0; auto_a = 1'b0;
        ld_b = 1'b0; ctd_b = 1'b0; ld_cnt_b = 0; cv_cnt_b = 0; cv_hold_b = 1'b0;
        ls_cnt_b = 0; clean_cnt_b = 0; done_cnt_b = 0; clean_at_done_b = 0;
        clean_prev_a = 1'b0;
        clear_a();
        repeat (3) tick();
        check("rst_outputs", {ls_a, clean_a, tv_a, busy_a, ldone_a}, 32'd0);
        check("rst_bases", bm_a | br_a | bc_a, 32'd0);
        check("rst_idx", idx_a, 32'd0);
        rst = 1'b1;
        tick();
        check("idle_busy", {31'd0, busy_a}, 32'd0);

        // Pass 1: full 8-tile layer, run re-pulsed at tile 3
        auto_a = 1'b1;
        clear_a();
        run_a = 1'b1;
        tick();
        busy_low = 0;
        rerun = 1'b0;
        for (int i = 0; i < 2000 && done_cnt_a == 0; i++) begin
            run_a = 1'b0;
            if (!busy_a) busy_low++;
            if (ls_a && idx_a == 32'd3 && !rerun) begin
                run_a = 1'b1;
                rerun = 1'b1;
            end
            tick();
        end
        run_a = 1'b0;
        check("p1_layer_done_seen", done_cnt_a, 1);
        check("p1_load_starts", ls_cnt_a, 8);
        check("p1_cleans", clean_cnt_a, 8);
        check("p1_busy_held", busy_low, 0);
        check("p1_clean_width", clean_wide_a, 0);
        check("p1_start_with_done_high", ls_ld_a, 0);
        k = 0;
        for (int m = 0; m < 16; m += 8)
            for (int r = 0; r < 32; r += 16)
                for (int c = 0; c < 16; c += 8) begin
                    o = (k < q_m_a.size()) ? q_m_a[k] : 32'hdead_beef;
                    check($sformatf("p1_m[%0d]", k), o, m);
                    o = (k < q_r_a.size()) ? q_r_a[k] : 32'hdead_beef;
                    check($sformatf("p1_row[%0d]", k), o, r);
                    o = (k < q_c_a.size()) ? q_c_a[k] : 32'hdead_beef;
                    check($sformatf("p1_col[%0d]", k), o, c);
                    o = (k < q_i_a.size()) ? q_i_a[k] : 32'hdead_beef;
                    check($sformatf("p1_idx[%0d]", k), o, k);
                    k++;
                end
        check("p1_finish_busy", {31'd0, busy_a}, 32'd0);
        check("p1_finish_bases", bm_a | br_a | bc_a, 32'd0);
        tick();
        check("p1_done_width", {31'd0, ldone_a}, 32'd0);
        repeat (3) tick();
        check("p1_single_done", done_cnt_a, 1);

        // Pass 2: C=20 gives three column tiles per row, 12 tiles
        run_b = 1'b1;
        tick();
        run_b = 1'b0;
        for (int i = 0; i < 3000 && done_cnt_b == 0; i++) tick();
        check("p2_layer_done_seen", done_cnt_b, 1);
        check("p2_load_starts", ls_cnt_b, 12);
        check("p2_cleans_at_done", clean_at_done_b, 12);
        k = 0;
        for (int m = 0; m < 16; m += 8)
            for (int r = 0; r < 32; r += 16)
                for (int c = 0; c < 20; c += 8) begin
                    o = (k < q_c_b.size()) ? q_c_b[k] : 32'hdead_beef;
                    check($sformatf("p2_col[%0d]", k), o, c);
                    o = (k < q_r_b.size()) ? q_r_b[k] : 32'hdead_beef;
                    check($sformatf("p2_row[%0d]", k), o, r);
                    o = (k < q_m_b.size()) ? q_m_b[k] : 32'hdead_beef;
                    check($sformatf("p2_m[%0d]", k), o, m);
                    k++;
                end

        // Pass 3: hand-driven handshakes on instance A
        auto_a = 1'b0;
        clear_a();
        tick();
        run_a = 1'b1;
        tick();
        run_a = 1'b0;
        check("m_issue", {31'd0, ls_a}, 32'd1);
        check("m_issue_busy", {31'd0, busy_a}, 32'd1);
        tick();
        check("m_wait_no_start", {31'd0, ls_a}, 32'd0);
        ctd_a = 1'b1;
        tick();
        ctd_a = 1'b0;
        check("m_conv_in_wait_tv", {31'd0, tv_a}, 32'd0);
        check("m_conv_in_wait_clean", {31'd0, clean_a}, 32'd0);
        ld_a = 1'b1;
        ctd_a = 1'b1;
        tick();
        ctd_a = 1'b0;
        check("m_both_tile_rdy", {31'd0, tv_a}, 32'd1);
        repeat (3) tick();
        check("m_conv_not_remembered", {30'd0, tv_a, clean_a}, 32'd2);
        ctd_a = 1'b1;
        tick();
        ctd_a = 1'b0;
        check("m_clean", {30'd0, clean_a, tv_a}, 32'd2);
        check("m_clean_col_stable", bc_a, 32'd0);
        tick();
        check("m_issue2_clean_once", {30'd0, ls_a, clean_a}, 32'd2);
        check("m_issue2_col", bc_a, 32'd8);
        check("m_issue2_idx", idx_a, 32'd1);
        tick();
        check("m_wait2_no_restart", {30'd0, ls_a, tv_a}, 32'd0);
        tick();
        check("m_wait2_done_taken", {31'd0, tv_a}, 32'd1);
        ld_a = 1'b0;

        // Pass 4: reset while tile 5 is in TILE_RDY, then a clean restart
        auto_a = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (tv_a && idx_a == 32'd5) break;
        end
        check("r_reached_tile5", {idx_a[30:0], tv_a}, {31'd5, 1'b1});
        check("r_tile5_col", bc_a, 32'd8);
        rst = 1'b0;
        #1;
        check("r_async_outputs", {ls_a, clean_a, tv_a, busy_a, ldone_a}, 32'd0);
        check("r_async_bases", bm_a | br_a | bc_a, 32'd0);
        check("r_async_idx", idx_a, 32'd0);
        auto_a = 1'b0;
        clear_a();
        tick();
        rst = 1'b1;
        tick();
        check("r_idle_after", {30'd0, busy_a, ls_a}, 32'd0);
        auto_a = 1'b1;
        clear_a();
        run_a = 1'b1;
        tick();
        run_a = 1'b0;
        for (int i = 0; i < 2000 && done_cnt_a == 0; i++) tick();
        o = (q_m_a.size() > 0) ? (q_m_a[0] | q_r_a[0] | q_c_a[0] | q_i_a[0]) : 32'hdead_beef;
        check("r_restart_base0", o, 32'd0);
        check("r_restart_starts", ls_cnt_a, 8);
        check("r_restart_done", done_cnt_a, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
